// File: rtl/prvp_c2c_slave_lane.sv
// C2C slave lane: oversamples a source-synchronous link on clk_axi and moves
// words between the DQ lanes and an RX/TX FIFO pair in 1/2/4/NUM_LANE-lane modes.
module prvp_c2c_slave_lane #(
    parameter int NUM_LANE   = 4,
    parameter int BW_WORD    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_axi,
    input  logic                rstnn_axi,
    input  logic                c2c_clk,
    input  logic                c2c_csn,
    input  logic [NUM_LANE-1:0] c2c_dq_sival,
    output logic [NUM_LANE-1:0] c2c_dq_soval,
    output logic [NUM_LANE-1:0] c2c_dq_sod,
    input  logic [1:0]          cfg_mode,
    input  logic                cfg_dir,
    output logic                rx_valid,
    output logic [BW_WORD-1:0]  rx_data,
    input  logic                rx_ready,
    input  logic                tx_valid,
    input  logic [BW_WORD-1:0]  tx_data,
    output logic                tx_ready,
    output logic                sts_ovf,
    output logic                sts_udf,
    output logic                sts_partial,
    input  logic                sts_clr
);
    localparam int CW = $clog2(BW_WORD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(NUM_LANE);

    typedef enum logic [1:0] {IDLE, RX, TX} state_t;

    state_t              state, state_next;
    logic [1:0]          mode_q;
    logic [2:0]          clk_sync, csn_sync;
    logic [NUM_LANE-1:0] dq_meta, dq_sync;
    logic                clk_rise, clk_fall, csn_rise, csn_fall;
    logic [1:0]          wlog;
    logic [3:0]          w_lanes;
    logic [NUM_LANE-1:0] lane_mask;
    logic [CW-1:0]       last_cnt;

    logic [BW_WORD-1:0]  rx_sr, rx_word_next, tx_sr;
    logic [CW-1:0]       rx_cnt, tx_cnt;
    logic                rx_edge, rx_done, tx_edge, tx_reload, enter_tx;

    logic [BW_WORD-1:0]  rx_mem [FIFO_DEPTH];
    logic [BW_WORD-1:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0]         rx_wp, rx_rp, tx_wp, tx_rp;
    logic                rx_empty, rx_full, rx_push, rx_pop;
    logic                tx_empty, tx_full, tx_push, tx_pop;
    logic                ovf_set, udf_set, partial_set;

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_axi) begin
        if (!rstnn_axi) begin
            clk_sync <= '0;
            csn_sync <= '1;
            dq_meta  <= '0;
            dq_sync  <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], c2c_clk};
            csn_sync <= {csn_sync[1:0], c2c_csn};
            dq_meta  <= c2c_dq_sival;
            dq_sync  <= dq_meta;
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_sync[2];
    assign clk_fall = ~clk_sync[1] & clk_sync[2];
    assign csn_rise = csn_sync[1] & ~csn_sync[2];
    assign csn_fall = ~csn_sync[1] & csn_sync[2];

    // Lanes per edge come from the mode latched at transfer start, not the live input.
    always_comb begin
        case (mode_q)
            2'b00:   wlog = 2'd0;
            2'b01:   wlog = 2'd1;
            2'b10:   wlog = 2'd2;
            default: wlog = LW[1:0];
        endcase
    end

    assign w_lanes   = 4'd1 << wlog;
    assign lane_mask = ~({NUM_LANE{1'b1}} << w_lanes);
    assign last_cnt  = CW'((BW_WORD >> wlog) - 1);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (csn_fall) state_next = cfg_dir ? TX : RX;
            default: if (csn_rise) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (!rstnn_axi) begin
            state  <= IDLE;
            mode_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && csn_fall) mode_q <= cfg_mode;
        end
    end

    assign enter_tx  = (state == IDLE) && csn_fall && cfg_dir;
    assign rx_edge   = (state == RX) && clk_rise && !csn_rise;
    assign rx_done   = rx_edge && (rx_cnt == last_cnt);
    assign tx_edge   = (state == TX) && clk_fall && !csn_rise;
    assign tx_reload = enter_tx || (tx_edge && (tx_cnt == last_cnt));

    assign rx_word_next = (rx_sr << w_lanes) | BW_WORD'(dq_sync & lane_mask);

    always_ff @(posedge clk_axi) begin
        if (!rstnn_axi) begin
            rx_sr  <= '0;
            rx_cnt <= '0;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else if (csn_rise) begin
            rx_cnt <= '0;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else begin
            if (rx_edge) begin
                rx_sr  <= rx_word_next;
                rx_cnt <= rx_done ? '0 : rx_cnt + 1'b1;
            end
            if (tx_reload) begin
                tx_sr  <= tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];
                tx_cnt <= '0;
            end else if (tx_edge) begin
                tx_sr  <= tx_sr << w_lanes;
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

    assign rx_valid = !rx_empty;
    assign rx_data  = rx_mem[rx_rp[AW-1:0]];
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = tx_reload && !tx_empty;

    assign ovf_set     = rx_done && rx_full && !rx_pop;
    assign udf_set     = tx_reload && tx_empty;
    assign partial_set = csn_rise && (state == RX) && (rx_cnt != '0);

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_axi) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_word_next;
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk_axi) begin
        if (!rstnn_axi) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // Sticky flags: a set event outranks a simultaneous clear.
    always_ff @(posedge clk_axi) begin
        if (!rstnn_axi) begin
            sts_ovf     <= 1'b0;
            sts_udf     <= 1'b0;
            sts_partial <= 1'b0;
        end else begin
            sts_ovf     <= ovf_set     | (sts_ovf     & ~sts_clr);
            sts_udf     <= udf_set     | (sts_udf     & ~sts_clr);
            sts_partial <= partial_set | (sts_partial & ~sts_clr);
        end
    end

    // Single-lane transmit uses lane 1; wider modes drive lanes [W-1:0], MSB on lane W-1.
    always_comb begin
        c2c_dq_soval = '0;
        c2c_dq_sod   = '0;
        if (state == TX) begin
            if (mode_q == 2'b00) begin
                c2c_dq_soval[1] = tx_sr[BW_WORD-1];
                c2c_dq_sod[1]   = 1'b1;
            end else begin
                c2c_dq_soval = NUM_LANE'(tx_sr >> (BW_WORD - int'(w_lanes)));
                c2c_dq_sod   = lane_mask;
            end
        end
    end
endmodule

// File: doc/prvp_c2c_slave_lane.md
PRVP_C2C_SLAVE_LANE -- requirements
Module: prvp_c2c_slave_lane

Interface
REQ-001 The block SHALL have parameter NUM_LANE, default 4, meaning physical DQ lane count (legal 4 or 8).
REQ-002 The block SHALL have parameter BW_WORD, default 32, meaning word width (multiple of 8 and of NUM_LANE).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries per RX and TX FIFO (power of 2, >=2).
REQ-004 The block SHALL use one clock and a synchronous active-low reset: clk_axi  in  1  sole clock; rstnn_axi  in  1  synchronous active-low reset.
REQ-005 The block SHALL have port c2c_clk  in  1  link clock, sampled as data.
REQ-006 The block SHALL have port c2c_csn  in  1  link chip select, active low.
REQ-007 The block SHALL have port c2c_dq_sival  in  NUM_LANE  lane input data.
REQ-008 The block SHALL have port c2c_dq_soval  out  NUM_LANE  lane output data.
REQ-009 The block SHALL have port c2c_dq_sod  out  NUM_LANE  per-lane output enable, 1 = drive.
REQ-010 The block SHALL have port cfg_mode  in  2  lanes per edge (W): 00=1, 01=2, 10=4, 11=NUM_LANE.
REQ-011 The block SHALL have port cfg_dir  in  1  transfer direction: 0 = receive, 1 = transmit.
REQ-012 The block SHALL have ports rx_valid out 1, rx_data out BW_WORD and rx_ready in 1, forming the RX word output handshake.
REQ-013 The block SHALL have ports tx_valid in 1, tx_data in BW_WORD and tx_ready out 1, forming the TX word input handshake.
REQ-014 The block SHALL have ports sts_ovf, sts_udf and sts_partial (out 1 each, sticky) and sts_clr (in 1, clear pulse).

Function
REQ-015 c2c_clk, c2c_csn and c2c_dq_sival SHALL each pass through a 2-flop synchronizer; an edge SHALL be detected by comparing the synchronized value against a third registered copy.
REQ-016 The FSM SHALL have three states, IDLE, RX and TX; the synchronized csn falling edge in IDLE SHALL move to RX if cfg_dir=0, or to TX if cfg_dir=1.
REQ-017 cfg_mode and cfg_dir SHALL be latched on leaving IDLE; changes while in RX or TX SHALL be ignored.
REQ-018 A synchronized csn rising edge SHALL return the FSM to IDLE from any state on the following cycle.
REQ-019 In RX, each synchronized c2c_clk rising edge SHALL shift {sr, dq[W-1:0]} into the shift register, with lane W-1 most significant and the word sent MSB first.
REQ-020 In RX with W=1, input SHALL be lane 0 only.
REQ-021 After BW_WORD/W edges, the assembled word SHALL be pushed into the RX FIFO and the edge counter SHALL wrap to 0.
REQ-022 A word completing while the RX FIFO is full SHALL be dropped and SHALL set sts_ovf; FIFO contents SHALL be unchanged.
REQ-023 rx_valid SHALL equal RX FIFO not-empty; the FIFO SHALL pop when rx_valid&rx_ready; push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-024 On entry to TX, the TX shift register SHALL load the FIFO head (pop) if available; otherwise it SHALL load all-zero and set sts_udf.
REQ-025 In TX, the top W bits of the shift register SHALL drive c2c_dq_soval[W-1:0], except with W=1, where the MSB SHALL drive lane 1 only.
REQ-026 In TX, each synchronized c2c_clk falling edge SHALL shift the register left by W bits; after BW_WORD/W falls, it SHALL reload per REQ-024.
REQ-027 tx_ready SHALL equal TX FIFO not-full; the FIFO SHALL push when tx_valid&tx_ready.
REQ-028 c2c_dq_sod SHALL be 1 only in TX, on lanes [W-1:0] (lane 1 only when W=1), and 0 elsewhere; undriven soval lanes SHALL be 0.
REQ-029 csn rising with a nonzero RX edge count SHALL discard the partial word and set sts_partial; a partial TX word SHALL be discarded silently.
REQ-030 sts_clr SHALL clear all sticky flags; a set event in the same cycle as sts_clr SHALL win.
REQ-031 Synchronized c2c_clk edges in IDLE SHALL be ignored.

Reset
REQ-032 While rstnn_axi=0 at a clk_axi edge, the FSM SHALL go to IDLE, both FIFOs SHALL empty, and counters, shift registers and synchronizers SHALL go to 0, with synchronized csn reset to 1.
REQ-033 After reset, rx_valid=0, tx_ready=1, c2c_dq_sod=0, c2c_dq_soval=0 and all sts_*=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no flag set; the first post-reset transfer SHALL require a fresh csn falling edge.

Verification
REQ-035 Quad RX (NUM_LANE=4, BW_WORD=32, mode 10): 8 edges carrying 0xDEADBEEF -> rx_data=0xDEADBEEF, rx_valid rises within 4 cycles of the 8th edge.
REQ-036 Single RX: 32 edges on lane 0 carrying 0x80000001 -> rx_data=0x80000001; c2c_dq_sod stays 0.
REQ-037 RX overflow (FIFO_DEPTH=4, rx_ready=0): 5 words sent -> 4 held, sts_ovf=1; the 5th is lost; sts_clr clears sts_ovf.
REQ-038 TX dual (mode 01): 0x12345678 queued -> 16 falling edges produce lanes[1:0] pairs 00,01,00,10...; sod=0011 during TX and 0000 after csn rises.
REQ-039 TX underflow: TX entered with empty FIFO -> soval=0, sts_udf=1.
REQ-040 Partial/reset: csn rises after 3 quad RX edges -> sts_partial=1, no push; reset mid-RX -> all outputs at reset values.
